// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package ssd_pkg;

    localparam int SSD_DIGITS = 8;
    localparam int SSD_WORD   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// index last+1 (mod N) and reports the winner one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Candidate indices in priority order, starting just after the last winner.
    logic [IW-1:0] w_cand [N];
    logic          w_found;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign w_cand[gi] = IW'((int'(last) + gi + 1) % N);
    end

    // Take the first candidate that is requesting.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (!w_found && req[w_cand[o]]) begin
                w_found          = 1'b1;
                gnt[w_cand[o]]   = 1'b1;
                gnt_idx          = w_cand[o];
            end
        end
    end

endmodule

// File: rtl/ssd_display_sched.sv
// Shares the 8-digit scan engine between several 32-bit producers: picks a
// requester round-robin, holds its value, starts the engine, and keeps the
// value up for at least DWELL frames before handing the display over.
module ssd_display_sched
    import ssd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*SSD_WORD-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     shift_strobe,
    output logic                     write_ready,
    output logic                     rollover_flag,
    output logic [SSD_WORD-1:0]      writeback,
    output logic [2:0]               cur_src,
    output logic                     busy
);

    localparam int         IW      = $clog2(NREQ);
    localparam logic [7:0] DW_LAST = 8'(DWELL - 1);

    sched_state_t        r_state;
    sched_state_t        w_state_next;
    logic [IW-1:0]       r_last;
    logic [7:0]          r_frame_cnt;
    logic                r_rollover;
    logic                r_roll_q;
    logic [SSD_WORD-1:0] r_writeback;
    logic [2:0]          r_cur_src;

    logic [NREQ-1:0]     w_gnt;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_grant;
    logic [SSD_WORD-1:0] w_gnt_data;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req     (req_valid),
        .last    (r_last),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_grant       = (r_state == IDLE) && (|req_valid);
    assign w_gnt_data    = req_data[SSD_WORD*int'(w_gnt_idx) +: SSD_WORD];
    assign rollover_flag = r_rollover;
    assign writeback     = r_writeback;
    assign cur_src       = r_cur_src;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs. The grant is masked by n_rst so a
    // producer never sees a ready pulse that the held-in-reset logic drops.
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        write_ready  = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (|req_valid) begin
                    w_state_next = LOAD;
                    req_ready    = w_gnt & {NREQ{n_rst}};
                end
            end
            LOAD: begin
                write_ready  = 1'b1;
                w_state_next = SHOW;
            end
            SHOW: begin
                if (shift_strobe && r_roll_q) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Held value, source index and round-robin pointer change only on a grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_writeback <= '0;
            r_cur_src   <= '0;
            r_last      <= IW'(NREQ - 1);
        end else if (w_grant) begin
            r_writeback <= w_gnt_data;
            r_cur_src   <= 3'(w_gnt_idx);
            r_last      <= w_gnt_idx;
        end
    end

    // Frame counting and the registered stop request. The flag is only raised
    // from SHOW so a stale count left over in IDLE cannot cut a fresh value short.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frame_cnt <= '0;
            r_rollover  <= 1'b0;
            r_roll_q    <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_frame_cnt <= '0;
            end else if (r_state == SHOW && shift_strobe && r_frame_cnt != DW_LAST) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            r_rollover <= (r_state == SHOW) && (r_frame_cnt == DW_LAST) && (|req_valid);
            r_roll_q   <= r_rollover;
        end
    end

endmodule
